// File: rtl/poly_tone_gen.sv
// poly_tone_gen: NUM_CH programmable 50% duty square-wave channels, mixed to one bit by a
// first-order sigma-delta modulator. Define POLY_TONE_IMMEDIATE_EN for legacy retrigger-on-write.
module poly_tone_gen #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int NUM_CH     = 4,
  parameter int PERIOD_W   = 25
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         enable,
  input  logic [NUM_CH-1:0]                            ch_enable,
  input  logic                                         wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [PERIOD_W-1:0]                          wr_period,
  output logic [NUM_CH-1:0]                            tone_out,
  output logic                                         pwm_out,
  output logic [NUM_CH-1:0]                            busy
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUM_W = $clog2(NUM_CH + 1);
  localparam int ACC_W = SUM_W + 1;

  // CLOCK_FREQ documents the clock domain only; nothing is derived from it.
  if (CLOCK_FREQ > 0) begin : g_clock_info
  end

  function automatic logic [SUM_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [SUM_W-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = c + SUM_W'(v[k]);
    end
    return c;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [PERIOD_W-1:0] active_r, pending_r, cnt_r;
    logic                pend_r, tone_r;
    logic [PERIOD_W-1:0] active_s, pending_s, cnt_s, half_s, new_half_s;
    logic                pend_s, tone_s, silent_s, apply_s, wr_hit_s;

    // Channel next-state: silent hold, counting, pending apply and period writes.
    always_comb begin
      active_s   = active_r;
      pending_s  = pending_r;
      cnt_s      = cnt_r;
      pend_s     = pend_r;
      tone_s     = tone_r;
      apply_s    = 1'b0;
      half_s     = {1'b0, active_r[PERIOD_W-1:1]};
      new_half_s = {1'b0, pending_r[PERIOD_W-1:1]};
      silent_s   = (half_s == '0) || !ch_enable[i];
      wr_hit_s   = wr_en && (wr_ch == CH_W'(i));

      if (silent_s) begin
        tone_s = 1'b0;
        if (pend_r) begin
          active_s = pending_r;
          cnt_s    = new_half_s;
          apply_s  = 1'b1;
        end else begin
          cnt_s = half_s;
        end
      end else if (enable) begin
`ifdef POLY_TONE_IMMEDIATE_EN
        if (pend_r) begin
          tone_s   = ~tone_r;
          active_s = pending_r;
          cnt_s    = new_half_s;
          apply_s  = 1'b1;
        end else if (cnt_r == '0) begin
          tone_s = ~tone_r;
          cnt_s  = half_s;
        end else begin
          cnt_s = cnt_r - PERIOD_W'(1);
        end
`else
        // A pending period is only taken at a half-wave boundary, so no level is truncated.
        if (cnt_r == '0) begin
          tone_s = ~tone_r;
          if (pend_r) begin
            active_s = pending_r;
            cnt_s    = new_half_s;
            apply_s  = 1'b1;
          end else begin
            cnt_s = half_s;
          end
        end else begin
          cnt_s = cnt_r - PERIOD_W'(1);
        end
`endif
      end else begin
        cnt_s = cnt_r;
      end

      // A write landing with an apply keeps the new value pending for the next boundary.
      if (wr_hit_s) begin
        pending_s = wr_period;
        pend_s    = 1'b1;
      end else if (apply_s) begin
        pend_s = 1'b0;
      end else begin
        pend_s = pend_r;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        active_r  <= '0;
        pending_r <= '0;
        cnt_r     <= '0;
        pend_r    <= 1'b0;
        tone_r    <= 1'b0;
      end else begin
        active_r  <= active_s;
        pending_r <= pending_s;
        cnt_r     <= cnt_s;
        pend_r    <= pend_s;
        tone_r    <= tone_s;
      end
    end

    assign tone_out[i] = tone_r;
    assign busy[i]     = pend_r;
  end

  logic [SUM_W-1:0] sum_s;
  logic [ACC_W:0]   total_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic             pwm_s;

  // Sigma-delta mixer: emit a 1 whenever the accumulated channel count reaches NUM_CH.
  always_comb begin
    sum_s   = popcount(tone_out);
    total_s = {1'b0, acc_r} + (ACC_W + 1)'(sum_s);
    if (!enable) begin
      acc_s = '0;
      pwm_s = 1'b0;
    end else if (total_s >= (ACC_W + 1)'(NUM_CH)) begin
      acc_s = ACC_W'(total_s - (ACC_W + 1)'(NUM_CH));
      pwm_s = 1'b1;
    end else begin
      acc_s = ACC_W'(total_s);
      pwm_s = 1'b0;
    end
  end

  // Mixer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r   <= '0;
      pwm_out <= 1'b0;
    end else begin
      acc_r   <= acc_s;
      pwm_out <= pwm_s;
    end
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Scoreboard bench for poly_tone_gen: stimulus queues cycle-tagged expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_poly_tone_gen;

  localparam int S_TONE = 0;
  localparam int S_BUSY = 1;
  localparam int S_PWM  = 2;
  localparam int S_TVEC = 3;
  localparam int S_BVEC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  ch_enable;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [24:0] wr_period;
  logic [3:0]  tone_out;
  logic        pwm_out;
  logic [3:0]  busy;

  poly_tone_gen #(
    .CLOCK_FREQ(100_000_000),
    .NUM_CH    (4),
    .PERIOD_W  (25)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .ch_enable(ch_enable),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_period(wr_period),
    .tone_out (tone_out),
    .pwm_out  (pwm_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    int          ch;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void compare(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [15:0] sample(input int sig, input int ch);
    logic [15:0] v;
    v = 16'h0000;
    case (sig)
      S_TONE:  v[0]   = tone_out[ch];
      S_BUSY:  v[0]   = busy[ch];
      S_PWM:   v[0]   = pwm_out;
      S_TVEC:  v[3:0] = tone_out;
      S_BVEC:  v[3:0] = busy;
      default: v      = 16'hDEAD;
    endcase
    return v;
  endfunction

  task automatic expect_at(input int c, input int sig, input int ch, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc = c; e.sig = sig; e.ch = ch; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        compare(sb[i].name, sample(sb[i].sig, sb[i].ch), sb[i].val);
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: never sampled, expected %0h at cycle %0d", sb[i].name, sb[i].val, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr(input int ch, input int per);
    wr_en     = 1'b1;
    wr_ch     = 2'(ch);
    wr_period = 25'(per);
    @(negedge clk);
    wr_en     = 1'b0;
  endtask

  int b, t, r, c;

  initial begin
    reset = 1'b1; enable = 1'b1; ch_enable = 4'hF;
    wr_en = 1'b0; wr_ch = 2'd0; wr_period = 25'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    b = cyc;
    t = b + 3;

    expect_at(b + 1, S_TVEC, 0, 16'h0, "rst_tone");
    expect_at(b + 1, S_BVEC, 0, 16'h0, "rst_busy");
    expect_at(b + 1, S_PWM,  0, 16'h0, "rst_pwm");
    // single tone, period 10: levels of 6 cycles, first rise at T+2+5
    expect_at(t,      S_BUSY, 0, 16'h1, "p10_busy_set");
    expect_at(t + 1,  S_BUSY, 0, 16'h0, "p10_busy_clr");
    expect_at(t + 6,  S_TONE, 0, 16'h0, "p10_pre_rise");
    expect_at(t + 7,  S_TONE, 0, 16'h1, "p10_rise");
    expect_at(t + 12, S_TONE, 0, 16'h1, "p10_high_end");
    expect_at(t + 13, S_TONE, 0, 16'h0, "p10_fall");
    expect_at(t + 18, S_TONE, 0, 16'h0, "p10_low_end");
    expect_at(t + 19, S_TONE, 0, 16'h1, "p10_rise2");
    expect_at(t + 10, S_PWM,  0, 16'h0, "mix1_pwm_a");
    expect_at(t + 11, S_PWM,  0, 16'h1, "mix1_pwm_b");
    expect_at(t + 12, S_PWM,  0, 16'h0, "mix1_pwm_c");
    // deferred update to period 20 three cycles after the rise at T+19
    expect_at(t + 21, S_BUSY, 0, 16'h0, "defer_busy_pre");
    expect_at(t + 22, S_BUSY, 0, 16'h1, "defer_busy_1");
    expect_at(t + 24, S_BUSY, 0, 16'h1, "defer_busy_3");
    expect_at(t + 25, S_BUSY, 0, 16'h0, "defer_busy_clr");
    expect_at(t + 24, S_TONE, 0, 16'h1, "defer_old_high");
    expect_at(t + 25, S_TONE, 0, 16'h0, "defer_fall");
    expect_at(t + 35, S_TONE, 0, 16'h0, "defer_low_end");
    expect_at(t + 36, S_TONE, 0, 16'h1, "defer_rise");
    expect_at(t + 46, S_TONE, 0, 16'h1, "defer_high_end");
    expect_at(t + 47, S_TONE, 0, 16'h0, "defer_fall2");
    // silence: period 1 then 0 on ch1
    expect_at(t + 28, S_BUSY, 1, 16'h1, "sil1_busy");
    expect_at(t + 29, S_BUSY, 1, 16'h0, "sil1_busy_clr");
    expect_at(t + 30, S_TONE, 1, 16'h0, "sil1_tone");
    expect_at(t + 32, S_BUSY, 1, 16'h1, "sil0_busy");
    expect_at(t + 33, S_BUSY, 1, 16'h0, "sil0_busy_clr");
    expect_at(t + 34, S_TONE, 1, 16'h0, "sil0_tone");
    // write coinciding with the cnt==0 edge at T+47 waits for the following boundary
    expect_at(t + 47, S_BUSY, 0, 16'h1, "edge_busy_set");
    expect_at(t + 57, S_BUSY, 0, 16'h1, "edge_busy_hold");
    expect_at(t + 58, S_BUSY, 0, 16'h0, "edge_busy_clr");
    expect_at(t + 57, S_TONE, 0, 16'h0, "edge_old_low");
    expect_at(t + 58, S_TONE, 0, 16'h1, "edge_rise");
    expect_at(t + 63, S_TONE, 0, 16'h1, "edge_new_high");
    expect_at(t + 64, S_TONE, 0, 16'h0, "edge_new_fall");

    wait_cyc(t - 1);  wr(0, 10);
    wait_cyc(t + 21); wr(0, 20);
    wait_cyc(t + 27); wr(1, 1);
    wait_cyc(t + 31); wr(1, 0);
    wait_cyc(t + 46); wr(0, 10);

    wait_cyc(t + 66);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ch_enable = 4'h0;
    r = cyc;
    c = r + 6;

    expect_at(r + 1, S_TVEC, 0, 16'h0, "rst2_tone");
    expect_at(r + 1, S_PWM,  0, 16'h0, "rst2_pwm");
    expect_at(r + 2, S_BVEC, 0, 16'h2, "dis_busy_r2");
    expect_at(r + 4, S_BVEC, 0, 16'h8, "dis_busy_r4");
    expect_at(r + 5, S_BVEC, 0, 16'h0, "dis_busy_r5");
    // all four in phase
    expect_at(c + 5,  S_TVEC, 0, 16'h0, "mix4_pre");
    expect_at(c + 6,  S_TVEC, 0, 16'hF, "mix4_rise");
    expect_at(c + 11, S_TVEC, 0, 16'hF, "mix4_high_end");
    expect_at(c + 12, S_TVEC, 0, 16'h0, "mix4_fall");
    expect_at(c + 6,  S_PWM,  0, 16'h0, "mix4_pwm_lag");
    expect_at(c + 7,  S_PWM,  0, 16'h1, "mix4_pwm_a");
    expect_at(c + 9,  S_PWM,  0, 16'h1, "mix4_pwm_b");
    expect_at(c + 12, S_PWM,  0, 16'h1, "mix4_pwm_c");
    expect_at(c + 13, S_PWM,  0, 16'h0, "mix4_pwm_off");
    // two channels: pwm alternates from acc=0
    expect_at(c + 17, S_TVEC, 0, 16'h0, "mix2_pre");
    expect_at(c + 18, S_TVEC, 0, 16'h3, "mix2_rise");
    for (int k = 0; k < 6; k++) begin
      expect_at(c + 19 + k, S_PWM, 0, 16'(k % 2), $sformatf("mix2_pwm_%0d", k));
    end
    // freeze for 50 cycles during the high phase
    expect_at(c + 33, S_PWM,  0, 16'h0, "frz_pwm_a");
    expect_at(c + 60, S_PWM,  0, 16'h0, "frz_pwm_b");
    expect_at(c + 81, S_PWM,  0, 16'h0, "frz_pwm_c");
    expect_at(c + 40, S_TVEC, 0, 16'h3, "frz_tone_a");
    expect_at(c + 81, S_TVEC, 0, 16'h3, "frz_tone_b");
    expect_at(c + 83, S_PWM,  0, 16'h1, "frz_resume_pwm1");
    expect_at(c + 84, S_PWM,  0, 16'h0, "frz_resume_pwm0");
    expect_at(c + 85, S_TVEC, 0, 16'h3, "frz_resume_high");
    expect_at(c + 86, S_TVEC, 0, 16'h0, "frz_resume_fall");
    expect_at(c + 92, S_TVEC, 0, 16'h3, "pre_rst_rise");
    expect_at(c + 93, S_TVEC, 0, 16'h3, "pre_rst_tone");
    expect_at(c + 93, S_PWM,  0, 16'h1, "pre_rst_pwm");
    expect_at(c + 93, S_BUSY, 2, 16'h1, "pre_rst_busy");

    wait_cyc(r);
    wr(0, 10); wr(1, 10); wr(2, 10); wr(3, 10);
    wait_cyc(c);      ch_enable = 4'hF;
    wait_cyc(c + 13); ch_enable = 4'h3;
    wait_cyc(c + 31); enable = 1'b0;
    wait_cyc(c + 81); enable = 1'b1;
    wait_cyc(c + 92); wr(2, 7);

    #2 reset = 1'b1;
    #1;
    compare("async_rst_tone", {12'h000, tone_out}, 16'h0);
    compare("async_rst_pwm",  {15'h0000, pwm_out}, 16'h0);
    compare("async_rst_busy", {12'h000, busy},     16'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: %0d expectations unchecked, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
